// File: rtl/led_mmio_pkg.sv
// led_mmio_pkg: register map and shared helpers
// for the memory-mapped LED controller.
package led_mmio_pkg;

  localparam logic [4:0] LED_DATA_OFS = 5'h00;
  localparam logic [4:0] CTRL_OFS     = 5'h04;
  localparam logic [4:0] PERIOD_OFS   = 5'h08;
  localparam logic [4:0] DUTY_OFS     = 5'h0C;
  localparam logic [4:0] STEPS_OFS    = 5'h10;

  localparam int CTRL_ROT_EN = 0;
  localparam int CTRL_DIR    = 1;
  localparam int CTRL_PWM_EN = 2;

  localparam logic [7:0] DUTY_FULL = 8'hFF;

  // Byte-lane merge of a write into an existing word.
  function automatic logic [31:0] be_merge(
    input logic [31:0] old_v,
    input logic [31:0] new_v,
    input logic [3:0]  be
  );
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/led_mmio_ctrl_pwm.sv
// led_pwm: 8-bit free-running PWM counter and
// duty compare used to dim the LED outputs.
module led_pwm
  import led_mmio_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] duty,
  output logic       on
);

  logic [7:0] cnt_q, cnt_d;

  // Count only while enabled; park at zero otherwise.
  always_comb begin
    cnt_d = en ? cnt_q + 8'd1 : 8'd0;
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 8'd0;
    else        cnt_q <= cnt_d;
  end

  assign on = !en || (duty == DUTY_FULL) || (cnt_q < duty);

endmodule

// File: rtl/led_mmio_ctrl.sv
// led_mmio_ctrl: LED pattern register with
// prescaled auto-rotation, PWM dimming, MMIO access.
module led_mmio_ctrl
  import led_mmio_pkg::*;
#(
  parameter int          NUM_LEDS       = 4,
  parameter logic [31:0] DEFAULT_PERIOD = 32'd50_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [4:0]          addr,
  input  logic [31:0]         wdata,
  input  logic [3:0]          we,
  input  logic                re,
  output logic [31:0]         rdata,
  output logic [NUM_LEDS-1:0] leds
);

  logic [NUM_LEDS-1:0] led_q, led_d, led_rot, leds_q;
  logic [2:0]          ctrl_q, ctrl_d;
  logic [31:0]         period_q, period_d;
  logic [7:0]          duty_q, duty_d;
  logic [31:0]         cnt_q, cnt_d;
  logic [31:0]         steps_q, steps_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [31:0]         rd_val, period_m1;
  logic [31:0]         led_wr, ctrl_wr, period_wr, duty_wr;
  logic [4:0]          ofs;
  logic                wr, wr_led, wr_ctrl, wr_period, wr_duty;
  logic                rot_en, tick, rot_rise, pwm_on;
  logic                unused;

  assign ofs       = {addr[4:2], 2'b00};
  assign wr        = |we;
  assign wr_led    = wr && (ofs == LED_DATA_OFS);
  assign wr_ctrl   = wr && (ofs == CTRL_OFS);
  assign wr_period = wr && (ofs == PERIOD_OFS);
  assign wr_duty   = wr && (ofs == DUTY_OFS);

  assign led_wr    = be_merge(32'(led_q), wdata, we);
  assign ctrl_wr   = be_merge(32'(ctrl_q), wdata, we);
  assign period_wr = be_merge(period_q, wdata, we);
  assign duty_wr   = be_merge(32'(duty_q), wdata, we);

  assign unused = ^{addr[1:0], led_wr >> NUM_LEDS,
                    ctrl_wr >> 3, duty_wr >> 8};

  assign rot_en    = ctrl_q[CTRL_ROT_EN];
  assign period_m1 = (period_q == '0) ? '0 : period_q - 32'd1;
  assign tick      = rot_en && (cnt_q == period_m1);
  assign rot_rise  = wr_ctrl && we[0] &&
                     wdata[CTRL_ROT_EN] && !rot_en;

  assign led_rot = ctrl_q[CTRL_DIR]
                 ? {led_q[0], led_q[NUM_LEDS-1:1]}
                 : {led_q[NUM_LEDS-2:0], led_q[NUM_LEDS-1]};

  led_pwm u_pwm (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ctrl_q[CTRL_PWM_EN]),
    .duty  (duty_q),
    .on    (pwm_on)
  );

  // Register writes, prescaler and rotator next-state.
  always_comb begin
    led_d    = led_q;
    ctrl_d   = ctrl_q;
    period_d = period_q;
    duty_d   = duty_q;
    cnt_d    = cnt_q + 32'd1;
    steps_d  = steps_q;
    if (tick) begin
      cnt_d   = '0;
      steps_d = steps_q + 32'd1;
      led_d   = led_rot;
    end
    unique case (1'b1)
      wr_led:    led_d  = led_wr[NUM_LEDS-1:0];
      wr_ctrl:   ctrl_d = ctrl_wr[2:0];
      wr_period: begin
        period_d = period_wr;
        cnt_d    = '0;
      end
      wr_duty:   duty_d = duty_wr[7:0];
      default: ;
    endcase
    if (!rot_en) cnt_d = '0;
    if (rot_rise) begin
      cnt_d   = '0;
      steps_d = '0;
    end
  end

  // Read mux; current register contents.
  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      ofs == LED_DATA_OFS: rd_val = 32'(led_q);
      ofs == CTRL_OFS:     rd_val = 32'(ctrl_q);
      ofs == PERIOD_OFS:   rd_val = period_q;
      ofs == DUTY_OFS:     rd_val = 32'(duty_q);
      ofs == STEPS_OFS:    rd_val = steps_q;
      default: ;
    endcase
    rdata_d = re ? rd_val : rdata_q;
  end

  // State registers and output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q    <= '0;
      ctrl_q   <= '0;
      period_q <= DEFAULT_PERIOD;
      duty_q   <= DUTY_FULL;
      cnt_q    <= '0;
      steps_q  <= '0;
      rdata_q  <= '0;
      leds_q   <= '0;
    end else begin
      led_q    <= led_d;
      ctrl_q   <= ctrl_d;
      period_q <= period_d;
      duty_q   <= duty_d;
      cnt_q    <= cnt_d;
      steps_q  <= steps_d;
      rdata_q  <= rdata_d;
      leds_q   <= led_q & {NUM_LEDS{pwm_on}};
    end
  end

  assign rdata = rdata_q;
  assign leds  = leds_q;

endmodule

// File: tb/tb_led_mmio_ctrl.sv
// tb_led_mmio_ctrl: table vectors, directed corner
// sequences and a random run against a reference model.
module tb_led_mmio_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  we = '0;
  logic        re = 1'b0;
  logic [31:0] rdata;
  logic [3:0]  leds;

  int checks = 0;
  int errors = 0;

  led_mmio_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (addr),
    .wdata (wdata),
    .we    (we),
    .re    (re),
    .rdata (rdata),
    .leds  (leds)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    logic [3:0]  be;
    logic        rd;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[22];

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    addr = '0; wdata = '0; we = '0; re = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a,
                    input logic [31:0] d);
    addr = a; wdata = d; we = 4'hF; re = 1'b0;
    cycle();
    idle();
  endtask

  task automatic rd(input logic [4:0] a,
                    output logic [31:0] d);
    addr = a; re = 1'b1; we = '0;
    cycle();
    idle();
    d = rdata;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    repeat (3) cycle();
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic wait_change(input logic [3:0] prev,
                             output int n);
    n = 0;
    while (leds === prev && n < 300) begin
      cycle();
      n++;
    end
  endtask

  function automatic logic [3:0] rot(input logic [3:0] v,
                                     input bit dir);
    logic [3:0] r;
    for (int i = 0; i < 4; i++)
      r[i] = dir ? v[(i + 1) % 4] : v[(i + 3) % 4];
    return r;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o,
                                        input logic [31:0] n,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  // Reference model state.
  logic [3:0]  m_led, m_leds;
  logic [2:0]  m_ctrl;
  logic [31:0] m_period, m_steps, m_rdata;
  logic [7:0]  m_duty;
  longint      m_elapsed;
  int          m_pwm;

  task automatic model_reset();
    m_led = 0; m_leds = 0; m_ctrl = 0;
    m_period = 32'd50_000; m_steps = 0; m_rdata = 0;
    m_duty = 8'hFF; m_elapsed = 0; m_pwm = 0;
  endtask

  function automatic logic [31:0] model_read(input int w);
    case (w)
      0: return {28'd0, m_led};
      1: return {29'd0, m_ctrl};
      2: return m_period;
      3: return {24'd0, m_duty};
      4: return m_steps;
      default: return 0;
    endcase
  endfunction

  task automatic model_step();
    longint p;
    bit tick, on, rise, anyw;
    int w;
    p = (m_period == 0) ? 1 : longint'(m_period);
    w = int'(addr >> 2);
    anyw = (we != 0);
    tick = m_ctrl[0] && (m_elapsed + 1 == p);
    on = !m_ctrl[2] || m_duty == 8'hFF || m_pwm < int'(m_duty);
    rise = anyw && w == 1 && we[0] && wdata[0] && !m_ctrl[0];
    m_leds = on ? m_led : 4'h0;
    if (re) m_rdata = model_read(w);
    m_pwm = m_ctrl[2] ? (m_pwm + 1) % 256 : 0;
    if (rise || (anyw && w == 2) || !m_ctrl[0] || tick)
      m_elapsed = 0;
    else
      m_elapsed++;
    if (rise) m_steps = 0;
    else if (tick) m_steps++;
    if (anyw && w == 0) m_led = merge({28'd0, m_led}, wdata, we) & 4'hF;
    else if (tick) m_led = rot(m_led, m_ctrl[1]);
    if (anyw && w == 1) m_ctrl = 3'(merge({29'd0, m_ctrl}, wdata, we));
    if (anyw && w == 2) m_period = merge(m_period, wdata, we);
    if (anyw && w == 3) m_duty = 8'(merge({24'd0, m_duty}, wdata, we));
  endtask

  initial begin
    logic [31:0] v;
    logic [3:0] exp_p;
    int n, cnt;
    logic [4:0] amap[7];

    tbl[0]  = '{5'h08, 32'h0,        4'h0, 1'b1, 32'h0000C350};
    tbl[1]  = '{5'h0C, 32'h0,        4'h0, 1'b1, 32'h000000FF};
    tbl[2]  = '{5'h00, 32'h0,        4'h0, 1'b1, 32'h0};
    tbl[3]  = '{5'h04, 32'h0,        4'h0, 1'b1, 32'h0};
    tbl[4]  = '{5'h10, 32'h0,        4'h0, 1'b1, 32'h0};
    tbl[5]  = '{5'h14, 32'h0,        4'h0, 1'b1, 32'h0};
    tbl[6]  = '{5'h0C, 32'h12345640, 4'h1, 1'b0, 32'h0};
    tbl[7]  = '{5'h0C, 32'h0,        4'h0, 1'b1, 32'h40};
    tbl[8]  = '{5'h08, 32'hAABBCCDD, 4'h4, 1'b0, 32'h40};
    tbl[9]  = '{5'h08, 32'h0,        4'h0, 1'b1, 32'h00BBC350};
    tbl[10] = '{5'h00, 32'hFFFFFFF5, 4'hE, 1'b0, 32'h00BBC350};
    tbl[11] = '{5'h00, 32'h0,        4'h0, 1'b1, 32'h0};
    tbl[12] = '{5'h00, 32'h5,        4'h1, 1'b0, 32'h0};
    tbl[13] = '{5'h00, 32'h0,        4'h0, 1'b1, 32'h5};
    tbl[14] = '{5'h00, 32'hA,        4'hF, 1'b1, 32'h5};
    tbl[15] = '{5'h00, 32'h0,        4'h0, 1'b1, 32'hA};
    tbl[16] = '{5'h1C, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0};
    tbl[17] = '{5'h10, 32'h1234,     4'hF, 1'b1, 32'h0};
    tbl[18] = '{5'h04, 32'hFFFFFFF8, 4'hF, 1'b1, 32'h0};
    tbl[19] = '{5'h04, 32'h0,        4'h0, 1'b1, 32'h0};
    tbl[20] = '{5'h0D, 32'h0,        4'h0, 1'b1, 32'h40};
    tbl[21] = '{5'h0C, 32'hFF,       4'h1, 1'b0, 32'h40};

    // Reset state and register map vectors.
    do_reset();
    check("rst_leds", {28'd0, leds}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    for (int i = 0; i < 22; i++) begin
      addr = tbl[i].a; wdata = tbl[i].d;
      we = tbl[i].be; re = tbl[i].rd;
      cycle();
      check($sformatf("vec%0d", i), rdata, tbl[i].exp);
    end
    idle();
    cycle();
    check("vec_leds", {28'd0, leds}, 32'hA);

    // Walking LED toward MSB.
    do_reset();
    wr(5'h00, 1); wr(5'h08, 10); wr(5'h04, 1);
    exp_p = 4'b0001;
    for (int s = 1; s <= 8; s++) begin
      wait_change(leds, n);
      exp_p = rot(exp_p, 1'b0);
      check($sformatf("up_gap%0d", s), n, (s == 1) ? 11 : 10);
      check($sformatf("up_pat%0d", s), {28'd0, leds}, {28'd0, exp_p});
    end
    rd(5'h10, v);
    check("up_steps", v, 32'd8);

    // Walking LED toward LSB, then PERIOD=0.
    do_reset();
    wr(5'h00, 1); wr(5'h08, 10); wr(5'h04, 3);
    exp_p = 4'b0001;
    for (int s = 1; s <= 4; s++) begin
      wait_change(leds, n);
      exp_p = rot(exp_p, 1'b1);
      check($sformatf("dn_gap%0d", s), n, (s == 1) ? 11 : 10);
      check($sformatf("dn_pat%0d", s), {28'd0, leds}, {28'd0, exp_p});
    end
    wr(5'h08, 0);
    cycle();
    check("p0_hold", {28'd0, leds}, {28'd0, exp_p});
    for (int s = 1; s <= 4; s++) begin
      cycle();
      exp_p = rot(exp_p, 1'b1);
      check($sformatf("p0_pat%0d", s), {28'd0, leds}, {28'd0, exp_p});
    end

    // LED_DATA write lands on a tick.
    do_reset();
    wr(5'h00, 1); wr(5'h08, 10); wr(5'h04, 1);
    repeat (9) cycle();
    wr(5'h00, 4'b0011);
    cycle();
    check("col_leds", {28'd0, leds}, 32'h3);
    rd(5'h10, v);
    check("col_steps", v, 32'd1);
    wait_change(leds, n);
    check("col_gap", n, 9);
    check("col_next", {28'd0, leds}, 32'h6);

    // PWM duty.
    do_reset();
    wr(5'h04, 4); wr(5'h0C, 32'h40); wr(5'h00, 4'hF);
    repeat (4) cycle();
    cnt = 0;
    for (int i = 0; i < 256; i++) begin
      if (leds == 4'hF) cnt++;
      cycle();
    end
    check("pwm_40", cnt, 64);
    wr(5'h0C, 0);
    repeat (3) cycle();
    cnt = 0;
    for (int i = 0; i < 256; i++) begin
      if (leds != 4'h0) cnt++;
      cycle();
    end
    check("pwm_00", cnt, 0);

    // Asynchronous reset mid-rotation.
    do_reset();
    wr(5'h00, 1); wr(5'h08, 3); wr(5'h04, 1);
    repeat (7) cycle();
    check("ar_pre", {31'd0, leds != 0}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_leds", {28'd0, leds}, 32'h0);
    #10;
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    rd(5'h08, v); check("ar_period", v, 32'd50_000);
    rd(5'h0C, v); check("ar_duty", v, 32'hFF);
    rd(5'h04, v); check("ar_ctrl", v, 32'h0);
    rd(5'h00, v); check("ar_led", v, 32'h0);
    repeat (30) cycle();
    rd(5'h10, v); check("ar_steps", v, 32'h0);
    check("ar_quiet", {28'd0, leds}, 32'h0);

    // Random traffic against the reference model.
    amap = '{5'h00, 5'h04, 5'h08, 5'h0C, 5'h10, 5'h14, 5'h1C};
    do_reset();
    model_reset();
    for (int i = 0; i < 4000; i++) begin
      addr = amap[$urandom_range(0, 6)] | 5'($urandom_range(0, 3));
      re = 1'($urandom_range(0, 1));
      we = '0;
      if ($urandom_range(0, 4) == 0)
        we = $urandom_range(0, 1) ? 4'hF : 4'($urandom_range(1, 15));
      wdata = $urandom;
      if ((addr >> 2) == 5'd2) wdata = $urandom_range(0, 7);
      if ((addr >> 2) == 5'd1 && $urandom_range(0, 3) != 0)
        wdata = wdata & 32'h7;
      model_step();
      cycle();
      check("rnd_leds", {28'd0, leds}, {28'd0, m_leds});
      check("rnd_rdata", rdata, m_rdata);
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
